// File: rtl/tt_um_jleugeri_ttt_pkg.sv
// Shared types for the token demultiplexer: FSM state encoding and
// index-width helpers used by the top and the testbench.
package tt_um_jleugeri_ttt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_READ,
        ST_ACC,
        ST_NEXT,
        ST_DONE
    } state_e;

    // Width of a processor index; never below one bit.
    function automatic int unsigned idx_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DEFAULT_PROCS = 10;
    localparam int unsigned DEFAULT_IW    = idx_bits(DEFAULT_PROCS);

endpackage

// File: rtl/tt_um_jleugeri_ttt_sat_acc.sv
// One signed token accumulator cell: synchronous clear, +1/-1 step.
// Macro TTT_DEMUX_SATURATE_EN selects clamping at the signed limits;
// without it the value wraps modulo 2^W.
module tt_um_jleugeri_ttt_sat_acc #(
    parameter int W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr_i,
    input  logic                add_i,
    input  logic                dec_i,
    output logic signed [W-1:0] val_o
);

    localparam logic signed [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

    logic signed [W-1:0] val_q, val_d, step;

    // Next value: clear wins over add; step is +1 or -1.
    always_comb begin
        step  = dec_i ? '1 : W'(1);
        val_d = val_q;
        if (clr_i) begin
            val_d = '0;
        end else if (add_i) begin
`ifdef TTT_DEMUX_SATURATE_EN
            if (dec_i ? (val_q == MINV) : (val_q == MAXV))
                val_d = val_q;
            else
                val_d = val_q + step;
`else
            val_d = val_q + step;
`endif
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) val_q <= '0;
        else       val_q <= val_d;
    end

    assign val_o = val_q;

endmodule

// File: rtl/tt_um_jleugeri_ttt_demux.sv
// Token demultiplexer: walks mux events, looks up each source's synapse
// range, reads every synapse and steps the target's good/bad accumulator
// by the event sign. Optional macro: TTT_DEMUX_SATURATE_EN (clamp
// accumulators instead of wrapping).
module tt_um_jleugeri_ttt_demux
    import tt_um_jleugeri_ttt_pkg::*;
#(
    parameter  int NUM_PROCESSORS  = 10,
    parameter  int NEW_TOKENS_BITS = 4,
    parameter  int SYN_ADDR_BITS   = 6,
    localparam int IW              = idx_bits(NUM_PROCESSORS)
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      start_in,
    input  logic                                      mux_hot_in,
    input  logic                                      mux_done_in,
    output logic                                      mux_go_out,
    output logic                                      mux_next_out,
    input  logic [IW-1:0]                             idx_src_in,
    input  logic                                      t_start_in,
    input  logic                                      t_stop_in,
    output logic [IW-1:0]                             range_idx_out,
    input  logic [SYN_ADDR_BITS-1:0]                  range_base_in,
    input  logic [SYN_ADDR_BITS-1:0]                  range_count_in,
    output logic [SYN_ADDR_BITS-1:0]                  syn_addr_out,
    output logic                                      syn_rd_out,
    input  logic [IW-1:0]                             syn_tgt_in,
    input  logic                                      syn_bad_in,
    output logic [NUM_PROCESSORS*NEW_TOKENS_BITS-1:0] new_good_tokens,
    output logic [NUM_PROCESSORS*NEW_TOKENS_BITS-1:0] new_bad_tokens,
    output logic                                      tokens_valid_out,
    output logic                                      busy_out
);

    localparam int N = NEW_TOKENS_BITS;

    state_e                   state_q;
    logic                     busy_q;
    logic                     pend_q;     // WAIT sub-phase: range lookup in flight
    logic [1:0]               sign_q;     // two's complement +1 / -1 / 0
    logic [IW-1:0]            range_idx_q;
    logic [SYN_ADDR_BITS-1:0] base_q, count_q, cnt_q, addr_q;
    logic [1:0]               sign_d;
    logic                     clr_all, acc_en;

    assign sign_d = {1'b0, t_start_in} - {1'b0, t_stop_in};

    // Strobes decoded from state; go is gated so reset forces it low.
    assign mux_go_out       = (state_q == ST_IDLE) && start_in && !reset;
    assign mux_next_out     = (state_q == ST_NEXT);
    assign syn_rd_out       = (state_q == ST_READ);
    assign tokens_valid_out = (state_q == ST_DONE);

    assign clr_all = mux_go_out;
    assign acc_en  = (state_q == ST_ACC) && (int'(syn_tgt_in) < NUM_PROCESSORS);

    assign busy_out      = busy_q;
    assign range_idx_out = range_idx_q;
    assign syn_addr_out  = addr_q;

    // Sweep FSM with its registered outputs and latches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            pend_q      <= 1'b0;
            sign_q      <= '0;
            range_idx_q <= '0;
            base_q      <= '0;
            count_q     <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_in) begin
                        state_q <= ST_WAIT;
                        busy_q  <= 1'b1;
                        pend_q  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (pend_q) begin
                        // Range table answers for range_idx_q this cycle.
                        pend_q <= 1'b0;
                        if (sign_q == 2'b00 || range_count_in == '0) begin
                            state_q <= ST_NEXT;
                        end else begin
                            base_q  <= range_base_in;
                            count_q <= range_count_in;
                            cnt_q   <= '0;
                            addr_q  <= range_base_in;
                            state_q <= ST_READ;
                        end
                    end else if (mux_done_in) begin
                        state_q <= ST_DONE;
                    end else if (mux_hot_in) begin
                        range_idx_q <= idx_src_in;
                        sign_q      <= sign_d;
                        pend_q      <= 1'b1;
                    end
                end
                ST_READ: state_q <= ST_ACC;
                ST_ACC: begin
                    if (cnt_q == count_q - 1'b1) begin
                        state_q <= ST_NEXT;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                        addr_q  <= base_q + cnt_q + 1'b1;
                        state_q <= ST_READ;
                    end
                end
                ST_NEXT: state_q <= ST_WAIT;
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Per-processor good/bad accumulator pair.
    for (genvar i = 0; i < NUM_PROCESSORS; i++) begin : g_proc
        logic hit;
        assign hit = acc_en && (syn_tgt_in == IW'(i));

        tt_um_jleugeri_ttt_sat_acc #(.W(N)) u_good (
            .clk   (clk),
            .reset (reset),
            .clr_i (clr_all),
            .add_i (hit && !syn_bad_in),
            .dec_i (sign_q[1]),
            .val_o (new_good_tokens[i*N +: N])
        );

        tt_um_jleugeri_ttt_sat_acc #(.W(N)) u_bad (
            .clk   (clk),
            .reset (reset),
            .clr_i (clr_all),
            .add_i (hit && syn_bad_in),
            .dec_i (sign_q[1]),
            .val_o (new_bad_tokens[i*N +: N])
        );
    end

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_demux.sv
// Directed bench for tt_um_jleugeri_ttt_demux with default parameters
// (10 processors, 4-bit accumulators, 6-bit synapse addresses).
module tb_tt_um_jleugeri_ttt_demux;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_in, mux_hot_in, mux_done_in, t_start_in, t_stop_in;
    logic        mux_go_out, mux_next_out, syn_rd_out, tokens_valid_out, busy_out;
    logic [3:0]  idx_src_in, range_idx_out, syn_tgt_in;
    logic        syn_bad_in;
    logic [5:0]  range_base_in, range_count_in, syn_addr_out;
    logic [39:0] new_good_tokens, new_bad_tokens;

    int checks = 0;
    int failures = 0;
    int next_cnt = 0;
    int tv_cnt = 0;
    logic [5:0] addr_log[$];

    always #5 clk = ~clk;

    tt_um_jleugeri_ttt_demux dut (
        .clk(clk), .reset(reset), .start_in(start_in),
        .mux_hot_in(mux_hot_in), .mux_done_in(mux_done_in),
        .mux_go_out(mux_go_out), .mux_next_out(mux_next_out),
        .idx_src_in(idx_src_in), .t_start_in(t_start_in), .t_stop_in(t_stop_in),
        .range_idx_out(range_idx_out), .range_base_in(range_base_in),
        .range_count_in(range_count_in), .syn_addr_out(syn_addr_out),
        .syn_rd_out(syn_rd_out), .syn_tgt_in(syn_tgt_in), .syn_bad_in(syn_bad_in),
        .new_good_tokens(new_good_tokens), .new_bad_tokens(new_bad_tokens),
        .tokens_valid_out(tokens_valid_out), .busy_out(busy_out)
    );

    // Range table: src -> (base, count)
    function automatic logic [5:0] base_of(input logic [3:0] s);
        case (s)
            4'd0: return 6'd10;
            4'd1: return 6'd62;
            4'd3: return 6'd5;
            4'd4: return 6'd20;
            default: return 6'd0;
        endcase
    endfunction
    function automatic logic [5:0] count_of(input logic [3:0] s);
        case (s)
            4'd0: return 6'd1;
            4'd1: return 6'd3;
            4'd3: return 6'd2;
            default: return 6'd0;
        endcase
    endfunction
    // Synapse memory: addr -> (target, bad)
    function automatic logic [3:0] tgt_of(input logic [5:0] a);
        case (a)
            6'd5:  return 4'd7;
            6'd6:  return 4'd2;
            6'd63: return 4'd12;
            default: return 4'd0;
        endcase
    endfunction
    function automatic logic bad_of(input logic [5:0] a);
        return (a == 6'd6) || (a == 6'd0);
    endfunction

    always_comb begin
        range_base_in  = base_of(range_idx_out);
        range_count_in = count_of(range_idx_out);
    end

    // One-cycle read latency synapse memory.
    always @(posedge clk) begin
        if (syn_rd_out) begin
            syn_tgt_in <= tgt_of(syn_addr_out);
            syn_bad_in <= bad_of(syn_addr_out);
        end
    end

    // Pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (syn_rd_out) addr_log.push_back(syn_addr_out);
        if (mux_next_out) next_cnt <= next_cnt + 1;
        if (tokens_valid_out) tv_cnt <= tv_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic start_sweep(output logic go_seen);
        start_in = 1'b1;
        #1 go_seen = mux_go_out;
        @(negedge clk);
        start_in = 1'b0;
    endtask

    // Present one event and hold it until acknowledged; lat = cycles to ack.
    task automatic send_event(input logic [3:0] src, input logic st, input logic sp,
                              output int lat);
        idx_src_in = src; t_start_in = st; t_stop_in = sp; mux_hot_in = 1'b1;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (mux_next_out) begin lat = k; break; end
        end
        mux_hot_in = 1'b0;
        @(negedge clk);
    endtask

    task automatic end_sweep(output int lat);
        mux_done_in = 1'b1; mux_hot_in = 1'b1;
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (tokens_valid_out) begin lat = k; break; end
        end
        mux_done_in = 1'b0; mux_hot_in = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic        go;
        int          lat, n0, nx0, tv0, seen;
        logic [39:0] eg, eb;

        reset = 1'b1; start_in = 1'b1; mux_hot_in = 1'b0; mux_done_in = 1'b0;
        t_start_in = 1'b0; t_stop_in = 1'b0; idx_src_in = '0;
        repeat (2) @(negedge clk);
        check("rst_go_gated", {63'd0, mux_go_out}, 64'd0);
        check("rst_busy", {63'd0, busy_out}, 64'd0);
        check("rst_good", new_good_tokens, 64'd0);
        check("rst_bad", new_bad_tokens, 64'd0);
        check("rst_addr_idx", {syn_addr_out, range_idx_out}, 64'd0);
        start_in = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", {63'd0, busy_out}, 64'd0);

        // Sweep A: single start event, then end of sweep.
        start_sweep(go);
        check("A_go", {63'd0, go}, 64'd1);
        check("A_busy", {63'd0, busy_out}, 64'd1);
        n0 = addr_log.size(); nx0 = next_cnt;
        send_event(4'd3, 1'b1, 1'b0, lat);
        check("A_lat", lat, 6);
        check("A_nreads", addr_log.size() - n0, 2);
        check("A_addr0", {58'd0, addr_log[n0]}, 64'd5);
        check("A_addr1", {58'd0, addr_log[n0+1]}, 64'd6);
        check("A_next_pulses", next_cnt - nx0, 1);
        check("A_next_low", {63'd0, mux_next_out}, 64'd0);
        check("A_range_idx", {60'd0, range_idx_out}, 64'd3);
        eg = '0; eg[7*4 +: 4] = 4'd1;
        eb = '0; eb[2*4 +: 4] = 4'd1;
        check("A_good", new_good_tokens, {24'd0, eg});
        check("A_bad", new_bad_tokens, {24'd0, eb});
        tv0 = tv_cnt;
        end_sweep(lat);
        check("A_done_lat", lat, 1);
        check("A_tv_pulses", tv_cnt - tv0, 1);
        check("A_idle", {63'd0, busy_out}, 64'd0);
        repeat (2) @(negedge clk);
        check("A_hold_good", new_good_tokens, {24'd0, eg});

        // Sweep B: clear, stop event, skipped events, wrapping range.
        start_sweep(go);
        check("B_cleared", {new_good_tokens, new_bad_tokens}, 80'd0);
        send_event(4'd3, 1'b0, 1'b1, lat);
        check("B_stop_lat", lat, 6);
        eg = '0; eg[7*4 +: 4] = 4'hF;
        eb = '0; eb[2*4 +: 4] = 4'hF;
        check("B_stop_good", new_good_tokens, {24'd0, eg});
        check("B_stop_bad", new_bad_tokens, {24'd0, eb});
        n0 = addr_log.size();
        send_event(4'd3, 1'b1, 1'b1, lat);
        check("B_zero_sign_lat", lat, 2);
        send_event(4'd4, 1'b1, 1'b0, lat);
        check("B_zero_count_lat", lat, 2);
        check("B_skip_noread", addr_log.size() - n0, 0);
        check("B_skip_tokens", {new_good_tokens, new_bad_tokens}, {eg, eb});
        n0 = addr_log.size();
        send_event(4'd1, 1'b1, 1'b0, lat);
        check("B_wrap_lat", lat, 8);
        check("B_wrap_addrs", {addr_log[n0], addr_log[n0+1], addr_log[n0+2]},
              {46'd0, 6'd62, 6'd63, 6'd0});
        eg[0 +: 4] = 4'd1;
        eb[0 +: 4] = 4'd1;
        check("B_wrap_good", new_good_tokens, {24'd0, eg});
        check("B_wrap_bad", new_bad_tokens, {24'd0, eb});
        end_sweep(lat);
        check("B_done_lat", lat, 1);

        // Sweep C: accumulator overflow on good[0].
        start_sweep(go);
        for (int e = 0; e < 8; e++) send_event(4'd0, 1'b1, 1'b0, lat);
`ifdef TTT_DEMUX_SATURATE_EN
        check("C_ovf8", new_good_tokens, 64'h7);
`else
        check("C_ovf8", new_good_tokens, 64'h8);
`endif
        send_event(4'd0, 1'b1, 1'b0, lat);
`ifdef TTT_DEMUX_SATURATE_EN
        check("C_ovf9", new_good_tokens, 64'h7);
`else
        check("C_ovf9", new_good_tokens, 64'h9);
`endif
        end_sweep(lat);

        // Sweep D: reset asserted while in ACC of the second synapse.
        start_sweep(go);
        idx_src_in = 4'd3; t_start_in = 1'b1; t_stop_in = 1'b0; mux_hot_in = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (syn_rd_out) seen++;
            if (seen == 2) break;
        end
        check("D_reads", seen, 2);
        @(negedge clk);
        eg = '0; eg[7*4 +: 4] = 4'd1;
        check("D_pre_good", new_good_tokens, {24'd0, eg});
        reset = 1'b1; mux_hot_in = 1'b0;
        #1;
        check("D_rst_tokens", {new_good_tokens, new_bad_tokens}, 80'd0);
        check("D_rst_regs", {busy_out, range_idx_out, syn_addr_out}, 64'd0);
        check("D_rst_strobes", {mux_go_out, mux_next_out, syn_rd_out, tokens_valid_out}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("D_stay_idle", {63'd0, busy_out}, 64'd0);
        start_sweep(go);
        check("D_restart_go", {63'd0, go}, 64'd1);
        send_event(4'd3, 1'b1, 1'b0, lat);
        check("D_restart_lat", lat, 6);
        eb = '0; eb[2*4 +: 4] = 4'd1;
        check("D_restart_tokens", {new_good_tokens, new_bad_tokens}, {eg, eb});
        end_sweep(lat);
        check("D_done_lat", lat, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
